// File: rtl/mem_bus.sv
// Memory bus controller: CPU address decode, local WRAM/HRAM/IE, external
// forwarding and the OAM DMA engine behind FF46.
module mem_bus #(
  parameter int DMA_BYTE_CLKS  = 4,
  parameter int DMA_START_CLKS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_rd_addr,
  output logic [7:0]  o_cpu_rd_data,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [15:0] o_ext_rd_addr,
  input  logic [7:0]  i_ext_rd_data,
  output logic        o_ext_wr_en,
  output logic [15:0] o_ext_wr_addr,
  output logic [7:0]  o_ext_wr_data,
  output logic        o_dma_active
);

  localparam logic [15:0] START_LAST = 16'(DMA_START_CLKS - 1);
  localparam logic [15:0] BYTE_LAST  = 16'(DMA_BYTE_CLKS - 1);
  localparam logic [7:0]  IDX_LAST   = 8'd159;

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;
  typedef enum logic [2:0] {REG_WRAM, REG_HRAM, REG_IE, REG_DMA, REG_EXT} region_t;

  function automatic region_t decode(input logic [15:0] a);
    if (a >= 16'hC000 && a <= 16'hFDFF) return REG_WRAM;
    else if (a == 16'hFFFF)             return REG_IE;
    else if (a >= 16'hFF80)             return REG_HRAM;
    else if (a == 16'hFF46)             return REG_DMA;
    else                                return REG_EXT;
  endfunction

  // Pages E0h and above fold down onto the WRAM echo.
  function automatic logic [15:0] dma_src(input logic [7:0] page, input logic [7:0] i);
    logic [7:0] p;
    p = (page >= 8'hE0) ? page - 8'h20 : page;
    return {p, i};
  endfunction

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [7:0]  idx;
  logic [7:0]  dma_reg;
  logic [7:0]  ie_reg;
  logic [7:0]  wram [0:8191];
  logic [7:0]  hram [0:126];
  region_t     rd_region, wr_region;
  logic        dma_active;
  logic        dma_wr;
  logic [15:0] src_addr;
  logic        src_is_wram;
  logic        byte_done;
  logic        last_byte;
  logic [7:0]  src_wram_p1;

  assign rd_region     = decode(i_cpu_rd_addr);
  assign wr_region     = decode(i_cpu_wr_addr);
  assign dma_active    = (state != IDLE);
  assign o_dma_active  = dma_active;
  assign dma_wr        = i_cpu_wr_en && (wr_region == REG_DMA);
  assign src_addr      = dma_src(dma_reg, idx);
  assign src_is_wram   = (src_addr[15:13] == 3'b110);
  assign byte_done     = (cnt == BYTE_LAST);
  assign last_byte     = (idx == IDX_LAST);
  assign o_ext_rd_addr = (state == ACTIVE) ? src_addr : i_cpu_rd_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dma_wr) state_nxt = START;
      START: begin
        if (dma_wr)                  state_nxt = START;
        else if (cnt == START_LAST)  state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (dma_wr)                     state_nxt = START;
        else if (byte_done && last_byte) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared counter: start delay in START, byte phase in ACTIVE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= 16'd0;
      idx <= 8'd0;
    end else if (dma_wr) begin
      cnt <= 16'd0;
      idx <= 8'd0;
    end else begin
      case (state)
        START: cnt <= (cnt == START_LAST) ? 16'd0 : cnt + 16'd1;
        ACTIVE: begin
          if (byte_done) begin
            cnt <= 16'd0;
            idx <= last_byte ? 8'd0 : idx + 8'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt <= 16'd0;
          idx <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dma_reg <= 8'h00;
      ie_reg  <= 8'h00;
    end else if (i_cpu_wr_en) begin
      if (wr_region == REG_DMA)                 dma_reg <= i_cpu_wr_data;
      if (wr_region == REG_IE && !dma_active)   ie_reg  <= i_cpu_wr_data;
    end
  end

  // Stage p1: DMA source byte from WRAM, address presented in phase 0.
  always_ff @(posedge i_clk) begin
    if (i_cpu_wr_en && wr_region == REG_WRAM && !dma_active)
      wram[i_cpu_wr_addr[12:0]] <= i_cpu_wr_data;
    if (i_cpu_wr_en && wr_region == REG_HRAM)
      hram[i_cpu_wr_addr[6:0]] <= i_cpu_wr_data;
    src_wram_p1 <= wram[src_addr[12:0]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cpu_rd_data <= 8'h00;
    end else if (dma_active && rd_region != REG_HRAM) begin
      o_cpu_rd_data <= 8'hFF;
    end else begin
      case (rd_region)
        REG_WRAM: o_cpu_rd_data <= wram[i_cpu_rd_addr[12:0]];
        REG_HRAM: o_cpu_rd_data <= hram[i_cpu_rd_addr[6:0]];
        REG_IE:   o_cpu_rd_data <= ie_reg;
        REG_DMA:  o_cpu_rd_data <= dma_reg;
        default:  o_cpu_rd_data <= i_ext_rd_data;
      endcase
    end
  end

  // Stage p2: external write port, owned by DMA whenever it is running.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ext_wr_en   <= 1'b0;
      o_ext_wr_addr <= 16'h0000;
      o_ext_wr_data <= 8'h00;
    end else begin
      o_ext_wr_en <= 1'b0;
      if (state == ACTIVE && cnt == 16'd1 && !dma_wr) begin
        o_ext_wr_en   <= 1'b1;
        o_ext_wr_addr <= {8'hFE, idx};
        o_ext_wr_data <= src_is_wram ? src_wram_p1 : i_ext_rd_data;
      end else if (!dma_active && i_cpu_wr_en && wr_region == REG_EXT) begin
        o_ext_wr_en   <= 1'b1;
        o_ext_wr_addr <= i_cpu_wr_addr;
        o_ext_wr_data <= i_cpu_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus.sv
// Bench for mem_bus: read/write paths, external forwarding and OAM DMA.
module tb_mem_bus;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] ext_rd_addr;
  logic [7:0]  ext_rd_data;
  logic        ext_wr_en;
  logic [15:0] ext_wr_addr;
  logic [7:0]  ext_wr_data;
  logic        dma_active;

  int checks = 0;
  int errors = 0;
  logic [7:0]  rd_q [$];
  logic [23:0] wr_q [$];

  always #5 clk = ~clk;

  // External memory model: low address byte plus 73h.
  function automatic logic [7:0] ext_fn(input logic [15:0] a);
    return a[7:0] + 8'h73;
  endfunction
  assign ext_rd_data = ext_fn(ext_rd_addr);

  mem_bus dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_rd_addr(rd_addr), .o_cpu_rd_data(rd_data),
    .i_cpu_wr_en(wr_en), .i_cpu_wr_addr(wr_addr), .i_cpu_wr_data(wr_data),
    .o_ext_rd_addr(ext_rd_addr), .i_ext_rd_data(ext_rd_data),
    .o_ext_wr_en(ext_wr_en), .o_ext_wr_addr(ext_wr_addr), .o_ext_wr_data(ext_wr_data),
    .o_dma_active(dma_active)
  );

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 16'h0; wr_data = 8'h0; rd_addr = 16'h0150;
    repeat (2) @(negedge clk);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (ext_wr_en !== 1'b0) begin errors++; $display("FAIL reset_ext_wr_en got %b want 0", ext_wr_en); end
    checks++; if (ext_wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_ext_wr_addr got %h want 0000", ext_wr_addr); end
    checks++; if (ext_wr_data !== 8'h00) begin errors++; $display("FAIL reset_ext_wr_data got %h want 00", ext_wr_data); end
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_dma_active got %b want 0", dma_active); end
    checks++; if (ext_rd_addr !== 16'h0150) begin errors++; $display("FAIL reset_ext_rd_addr got %h want 0150", ext_rd_addr); end
    rst = 1'b0;
    rd_addr = 16'hFF46; rd_q.push_back(8'h00);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL reset_dma_reg got %h want %h", rd_data, exp); end
    rd_addr = 16'hFFFF; rd_q.push_back(8'h00);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL reset_ie got %h want %h", rd_data, exp); end
  endtask

  task automatic test_wram();
    logic [15:0] a [5];
    logic [7:0]  e [5];
    logic [7:0]  exp;
    a = '{16'hC123, 16'hE123, 16'hD000, 16'hFDFF, 16'hC300};
    e = '{8'h5A, 8'h5A, 8'h11, 8'h9E, 8'h12};
    cpu_write(16'hC123, 8'h5A);
    cpu_write(16'hD000, 8'h11);
    cpu_write(16'hDDFF, 8'h9E);
    cpu_write(16'hC300, 8'h12);
    for (int i = 0; i < 5; i++) begin
      rd_addr = a[i]; rd_q.push_back(e[i]);
      @(negedge clk); exp = rd_q.pop_front();
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL wram_read addr=%h got %h want %h", a[i], rd_data, exp); end
    end
    // read and write of the same address on one edge
    rd_addr = 16'hC300; wr_en = 1'b1; wr_addr = 16'hC300; wr_data = 8'h34; rd_q.push_back(8'h12);
    @(negedge clk); wr_en = 1'b0; exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL wram_same_edge_old got %h want %h", rd_data, exp); end
    rd_q.push_back(8'h34);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL wram_same_edge_new got %h want %h", rd_data, exp); end
  endtask

  task automatic test_hram_ie();
    logic [15:0] a [5];
    logic [7:0]  e [5];
    logic [7:0]  exp;
    a = '{16'hFF90, 16'hFFFF, 16'hFFFE, 16'h0150, 16'hFEA0};
    e = '{8'h3C, 8'h01, 8'hE7, 8'hC3, 8'h13};
    cpu_write(16'hFF90, 8'h3C);
    cpu_write(16'hFFFF, 8'h01);
    cpu_write(16'hFFFE, 8'hE7);
    cpu_write(16'hFF80, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      rd_addr = a[i]; rd_q.push_back(e[i]);
      @(negedge clk); exp = rd_q.pop_front();
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL hram_ie_ext_read addr=%h got %h want %h", a[i], rd_data, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa [4];
    logic [7:0]  wd [4];
    logic        fwd [4];
    logic        expect_en;
    logic [23:0] exp, got;
    wa = '{16'h8000, 16'hC400, 16'hFF00, 16'hA000};
    wd = '{8'h77, 8'h21, 8'h12, 8'h5C};
    fwd = '{1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        wr_en = 1'b1; wr_addr = wa[c]; wr_data = wd[c];
        if (fwd[c]) wr_q.push_back({wa[c], wd[c]});
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      expect_en = (c < 4) && fwd[c];
      checks++; if (ext_wr_en !== expect_en) begin errors++; $display("FAIL ext_wr_strobe cyc=%0d got %b want %b", c, ext_wr_en, expect_en); end
      if (ext_wr_en === 1'b1 && wr_q.size() > 0) begin
        exp = wr_q.pop_front(); got = {ext_wr_addr, ext_wr_data};
        checks++; if (got !== exp) begin errors++; $display("FAIL ext_wr_payload got %h want %h", got, exp); end
      end
    end
    wr_en = 1'b0;
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL ext_wr_missing got %0d left want 0", wr_q.size()); end
    wr_q.delete();
  endtask

  task automatic test_dma_basic();
    int cyc, act, strobes, next_exp;
    logic rd_pend, done;
    logic [7:0] exp;
    logic [23:0] e24, got;
    @(negedge clk);
    for (int n = 0; n < 160; n++) begin
      wr_en = 1'b1; wr_addr = 16'hC000 + 16'(n); wr_data = 8'(n);
      @(negedge clk);
    end
    wr_en = 1'b1; wr_addr = 16'hFF46; wr_data = 8'hC0;
    for (int n = 0; n < 160; n++) wr_q.push_back({16'hFE00 + 16'(n), 8'(n)});
    cyc = 0; act = 0; strobes = 0; next_exp = 7; rd_pend = 1'b0; done = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk); cyc++; wr_en = 1'b0;
      if (rd_pend) begin
        exp = rd_q.pop_front(); rd_pend = 1'b0;
        checks++; if (rd_data !== exp) begin errors++; $display("FAIL dma_cpu_read cyc=%0d got %h want %h", cyc, rd_data, exp); end
      end
      if (dma_active === 1'b1) act++;
      if (ext_wr_en === 1'b1) begin
        checks++; if (cyc != next_exp) begin errors++; $display("FAIL dma_strobe_time got %0d want %0d", cyc, next_exp); end
        next_exp = cyc + 4; strobes++;
        checks++;
        if (wr_q.size() == 0) begin errors++; $display("FAIL dma_extra_strobe got %h want none", {ext_wr_addr, ext_wr_data}); end
        else begin
          e24 = wr_q.pop_front(); got = {ext_wr_addr, ext_wr_data};
          if (got !== e24) begin errors++; $display("FAIL dma_payload got %h want %h", got, e24); end
        end
      end
      if (cyc == 100) begin rd_addr = 16'hC000; rd_q.push_back(8'hFF); rd_pend = 1'b1; end
      if (cyc == 101) begin rd_addr = 16'hFF80; rd_q.push_back(8'hA5); rd_pend = 1'b1; end
      if (cyc == 200) begin wr_en = 1'b1; wr_addr = 16'hC000; wr_data = 8'hAA; end
      if (cyc == 201) begin wr_en = 1'b1; wr_addr = 16'h8000; wr_data = 8'h66; end
      if (cyc == 202) begin wr_en = 1'b1; wr_addr = 16'hFFFF; wr_data = 8'hFF; end
      if (act > 0 && dma_active === 1'b0) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL dma_timeout got %0d cycles want end of DMA", cyc); end
    checks++; if (act != 644) begin errors++; $display("FAIL dma_active_len got %0d want 644", act); end
    checks++; if (strobes != 160) begin errors++; $display("FAIL dma_strobe_count got %0d want 160", strobes); end
    wr_q.delete();
    rd_addr = 16'hC000; rd_q.push_back(8'h00);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL dma_dropped_wram got %h want %h", rd_data, exp); end
    rd_addr = 16'hFF46; rd_q.push_back(8'hC0);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL dma_reg_read got %h want %h", rd_data, exp); end
    rd_addr = 16'hFFFF; rd_q.push_back(8'h01);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL dma_dropped_ie got %h want %h", rd_data, exp); end
  endtask

  task automatic test_restart();
    int cyc, act, strobes, next_exp;
    logic done;
    logic [23:0] e24, got;
    @(negedge clk);
    for (int n = 0; n < 160; n++) begin
      wr_en = 1'b1; wr_addr = 16'hC100 + 16'(n); wr_data = ~8'(n);
      @(negedge clk);
    end
    wr_en = 1'b1; wr_addr = 16'hFF46; wr_data = 8'hE1;
    for (int n = 0; n < 160; n++) wr_q.push_back({16'hFE00 + 16'(n), ~8'(n)});
    cyc = 0; act = 0; strobes = 0; next_exp = 7; done = 1'b0;
    while (!done && cyc < 1200) begin
      @(negedge clk); cyc++; wr_en = 1'b0;
      if (dma_active === 1'b1) act++;
      if (ext_wr_en === 1'b1) begin
        checks++; if (cyc != next_exp) begin errors++; $display("FAIL restart_strobe_time got %0d want %0d", cyc, next_exp); end
        next_exp = cyc + 4; strobes++;
        checks++;
        if (wr_q.size() == 0) begin errors++; $display("FAIL restart_extra_strobe got %h want none", {ext_wr_addr, ext_wr_data}); end
        else begin
          e24 = wr_q.pop_front(); got = {ext_wr_addr, ext_wr_data};
          if (got !== e24) begin errors++; $display("FAIL restart_payload got %h want %h", got, e24); end
        end
      end
      if (cyc == 49) begin
        wr_en = 1'b1; wr_addr = 16'hFF46; wr_data = 8'h02;
        wr_q.delete();
        for (int n = 0; n < 160; n++) wr_q.push_back({16'hFE00 + 16'(n), 8'(n) + 8'h73});
        next_exp = 56;
      end
      if (act > 0 && dma_active === 1'b0) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL restart_timeout got %0d cycles want end of DMA", cyc); end
    checks++; if (act != 693) begin errors++; $display("FAIL restart_active_len got %0d want 693", act); end
    checks++; if (strobes != 171) begin errors++; $display("FAIL restart_strobe_count got %0d want 171", strobes); end
    wr_q.delete();
  endtask

  task automatic test_reset_mid_dma();
    int cyc, strobes, late_strobes, late_active;
    logic [7:0] exp;
    logic [23:0] e24, got;
    rd_addr = 16'hFF80;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 16'hFF46; wr_data = 8'hC0;
    for (int n = 0; n < 160; n++) wr_q.push_back({16'hFE00 + 16'(n), 8'(n)});
    cyc = 0; strobes = 0;
    while (strobes < 51 && cyc < 400) begin
      @(negedge clk); cyc++; wr_en = 1'b0;
      if (ext_wr_en === 1'b1) begin
        strobes++;
        e24 = wr_q.pop_front(); got = {ext_wr_addr, ext_wr_data};
        checks++; if (got !== e24) begin errors++; $display("FAIL rstdma_payload got %h want %h", got, e24); end
      end
    end
    checks++; if (strobes != 51) begin errors++; $display("FAIL rstdma_timeout got %0d strobes want 51", strobes); end
    rst = 1'b1;
    #1;
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL rstdma_active got %b want 0", dma_active); end
    checks++; if (ext_wr_en !== 1'b0) begin errors++; $display("FAIL rstdma_wr_en got %b want 0", ext_wr_en); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rstdma_rd_data got %h want 00", rd_data); end
    checks++; if ({ext_wr_addr, ext_wr_data} !== 24'h0) begin errors++; $display("FAIL rstdma_wr_bus got %h want 000000", {ext_wr_addr, ext_wr_data}); end
    wr_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    late_strobes = 0; late_active = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (ext_wr_en === 1'b1) late_strobes++;
      if (dma_active === 1'b1) late_active++;
    end
    checks++; if (late_strobes != 0) begin errors++; $display("FAIL rstdma_late_strobes got %0d want 0", late_strobes); end
    checks++; if (late_active != 0) begin errors++; $display("FAIL rstdma_late_active got %0d want 0", late_active); end
    rd_addr = 16'hFF46; rd_q.push_back(8'h00);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL rstdma_dma_reg got %h want %h", rd_data, exp); end
    rd_addr = 16'hFFFF; rd_q.push_back(8'h00);
    @(negedge clk); exp = rd_q.pop_front();
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL rstdma_ie got %h want %h", rd_data, exp); end
  endtask

  initial begin
    test_reset();
    test_wram();
    test_hram_ie();
    test_back_to_back();
    test_dma_basic();
    test_restart();
    test_reset_mid_dma();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus.md
# mem_bus

Memory bus controller between the CPU core's memory port and the rest of the system. Decodes every CPU read/write address, serves internal WRAM (8 KiB, with echo), HRAM (127 B) and the IE register locally, forwards all other regions to an external port, and owns the OAM DMA engine triggered by writes to FF46h. The CPU's single read port and single write port connect here unchanged.

## Interface
- DMA_BYTE_CLKS, 4: clocks per DMA byte (one M-cycle); must be ≥3.
- DMA_START_CLKS, 4: clocks from the FF46 write to the first DMA byte.
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cpu_rd_addr  in  16  CPU read address, sampled every clock
- o_cpu_rd_data  out  8  registered read data for the address sampled on the previous edge
- i_cpu_wr_en  in  1  CPU write strobe, one-clock pulse
- i_cpu_wr_addr  in  16  CPU write address
- i_cpu_wr_data  in  8  CPU write data
- o_ext_rd_addr  out  16  external read address, combinational
- i_ext_rd_data  in  8  external read data, combinational response to o_ext_rd_addr
- o_ext_wr_en  out  1  external write strobe, registered, one clock
- o_ext_wr_addr  out  16  external write address, registered
- o_ext_wr_data  out  8  external write data, registered
- o_dma_active  out  1  high from the FF46 write until the last OAM byte is written

## Operation
- Address map: C000–DFFF WRAM; E000–FDFF echo of C000–DDFF (addr − 2000h); FF80–FFFE HRAM; FFFF IE register; FF46 DMA register; all else external (ROM, VRAM, ext RAM, OAM, FEA0–FEFF, IO).
- Read path: each edge, o_cpu_rd_data <= value at i_cpu_rd_addr; WRAM and HRAM are synchronous-read arrays; external data is i_ext_rd_data captured on the same edge; FF46 and FFFF return the last written value.
- Write path: when i_cpu_wr_en, internal targets written on that edge; external targets produce o_ext_wr_en=1 with captured addr/data on the following clock.
- Same-edge read and write to the same internal address: read returns old data.
- o_ext_rd_addr = i_cpu_rd_addr when not in ACTIVE; DMA source address when in ACTIVE.
- DMA FSM: IDLE → START on any CPU write to FF46 (value XX latched); START holds DMA_START_CLKS clocks → ACTIVE; ACTIVE transfers idx 0..159 → IDLE.
- Source = {XX,idx}; if XX ≥ E0h use XX − 20h. Source in C000–DFFF read from WRAM, otherwise via o_ext_rd_addr. Destination FE00h+idx via external write port.
- Per byte, phase counter 0..DMA_BYTE_CLKS−1: phase 0 present source address; phase 1 latch byte; phase 2 o_ext_wr_en=1, o_ext_wr_addr=FE00h+idx; then idx+1 at last phase.
- While o_dma_active: CPU reads outside FF80–FFFE return FFh; CPU writes outside FF80–FFFE dropped, except FF46, which restarts the FSM at START with the new XX and idx=0.
- CPU external writes during DMA are never forwarded; DMA owns the external write port.

## Timing
- Reset values: o_cpu_rd_data=00h, o_ext_wr_en=0, o_ext_wr_addr=0000h, o_ext_wr_data=00h, o_dma_active=0, DMA register=00h, IE=00h, FSM=IDLE, idx=0. WRAM/HRAM contents not reset.
- Read latency 1 clock for every region.
- External write latency 1 clock; strobe width exactly 1 clock.
- o_dma_active rises the clock after the FF46 write edge and falls after the final write; total high time DMA_START_CLKS + 160×DMA_BYTE_CLKS (644 at defaults).
- Reset mid-DMA: FSM to IDLE immediately, no further OAM writes; o_ext_wr_en low asynchronously.
- idx is 8 bits, terminates at 159; never wraps into FEA0h.

## Test plan
- Write 5Ah to C123, read C123 and E123 -> both return 5Ah one clock after address; read D000 after writing D000=11h -> 11h.
- Write 3Ch to FF90 and 01h to FFFF, read back -> 3Ch, 01h; read 0150h with i_ext_rd_data=C3h -> C3h one clock later.
- CPU write 77h to 8000h -> o_ext_wr_en high exactly one clock, addr 8000h, data 77h, the clock after the strobe.
- Preload C000–C09F with idx, write C0h to FF46 -> 160 strobes at FE00+n carrying n, every 4 clocks; o_dma_active high 644 clocks; during DMA read C000 -> FFh, read FF80 -> HRAM value.
- Write FF46=E1h -> sources read from C100h onward; second FF46 write mid-transfer -> restart at idx 0.
- Assert i_rst at idx 50 -> o_dma_active=0, o_ext_wr_en=0 immediately, no further writes; all outputs at reset values.
